// File: rtl/count_ctrl_pkg.sv
// Shared opcodes, FSM states and status-byte layout for the count gate controller.
package count_ctrl_pkg;

  localparam logic [7:0] OP_START    = 8'h01;
  localparam logic [7:0] OP_STOP     = 8'h02;
  localparam logic [7:0] OP_CLEAR    = 8'h03;
  localparam logic [7:0] OP_SET_GATE = 8'h10;
  localparam logic [7:0] OP_READ     = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    ARG_HI,
    ARG_LO,
    GATING,
    READOUT
  } state_e;

  localparam int unsigned ST_BUSY = 7;
  localparam int unsigned ST_DONE = 6;
  localparam int unsigned ST_OVF  = 5;
  localparam int unsigned ST_ERR  = 4;

  // Status byte as seen by the SPI host: {busy, done, ovf, err, 4'b0}.
  function automatic logic [7:0] make_status(input logic busy, input logic done,
                                             input logic ovf, input logic err);
    logic [7:0] s;
    s          = 8'h00;
    s[ST_BUSY] = busy;
    s[ST_DONE] = done;
    s[ST_OVF]  = ovf;
    s[ST_ERR]  = err;
    return s;
  endfunction

endpackage

// File: rtl/count_gate_controller_gate_timer.sv
// Gate-length down-counter: loaded at START, decremented on every enabled cycle.
module gate_timer #(
  parameter int unsigned GATE_W = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load,
  input  logic [GATE_W-1:0] load_val,
  input  logic              run,
  output logic              expire_c
);

  logic [GATE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (run && (count_q != '0)) begin
      count_d = count_q - GATE_W'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Final enabled cycle of the window is the one that sees one count left.
  assign expire_c = run && (count_q <= GATE_W'(1));

endmodule

// File: rtl/count_gate_controller.sv
// SPI command sequencer: decodes host opcodes, runs the counter gate window and
// returns a snapshot of the count MSB-first, otherwise presenting the status byte.
module count_gate_controller
  import count_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W      = 16,
  parameter int unsigned GATE_W       = 16,
  parameter int unsigned DEFAULT_GATE = 1000
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic [7:0]         tx_data,
  output logic               tx_update,
  output logic               cnt_enable,
  output logic               cnt_clear,
  input  logic [COUNT_W-1:0] cnt_value,
  input  logic               cnt_tc,
  output logic               busy,
  output logic               gate_done
);

  localparam int unsigned CNT_BYTES = COUNT_W / 8;
  localparam int unsigned BYTES_W   = $clog2(CNT_BYTES) + 1;

  state_e              state_q, state_d;
  logic [GATE_W-1:0]   gate_len_q, gate_len_d;
  logic [7:0]          arg_hi_q, arg_hi_d;
  logic [COUNT_W-1:0]  shadow_q, shadow_d;
  logic [BYTES_W-1:0]  bytes_left_q, bytes_left_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_update_q, tx_update_d;
  logic                cnt_enable_q, cnt_enable_d;
  logic                cnt_clear_q, cnt_clear_d;
  logic                busy_q, busy_d;
  logic                gate_done_q, gate_done_d;

  logic                timer_load;
  logic                timer_expire_c;
  logic                end_gate;
  logic                present;
  logic                readout_end;
  logic [7:0]          present_byte;
  logic [7:0]          status_d;

  gate_timer #(
    .GATE_W(GATE_W)
  ) u_gate_timer (
    .clock    (clock),
    .rst      (rst),
    .load     (timer_load),
    .load_val (gate_len_q),
    .run      (cnt_enable_q),
    .expire_c (timer_expire_c)
  );

  always_comb begin
    state_d      = state_q;
    gate_len_d   = gate_len_q;
    arg_hi_d     = arg_hi_q;
    shadow_d     = shadow_q;
    bytes_left_d = bytes_left_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    tx_data_d    = tx_data_q;
    tx_update_d  = 1'b0;
    cnt_enable_d = 1'b0;
    cnt_clear_d  = 1'b0;
    gate_done_d  = 1'b0;
    timer_load   = 1'b0;
    end_gate     = 1'b0;
    present      = 1'b0;
    readout_end  = 1'b0;
    present_byte = 8'h00;
    status_d     = 8'h00;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_START: begin
              cnt_clear_d = 1'b1;
              done_d      = 1'b0;
              ovf_d       = 1'b0;
              timer_load  = 1'b1;
              state_d     = GATING;
            end
            OP_STOP: ;
            OP_CLEAR: begin
              cnt_clear_d = 1'b1;
              done_d      = 1'b0;
              ovf_d       = 1'b0;
              err_d       = 1'b0;
            end
            OP_SET_GATE: state_d = ARG_HI;
            OP_READ: begin
              shadow_d     = cnt_value;
              bytes_left_d = BYTES_W'(CNT_BYTES - 1);
              present      = 1'b1;
              present_byte = cnt_value[COUNT_W-1 -: 8];
              state_d      = READOUT;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ARG_HI: begin
        if (rx_valid) begin
          arg_hi_d = rx_data;
          state_d  = ARG_LO;
        end
      end

      ARG_LO: begin
        if (rx_valid) begin
          gate_len_d = GATE_W'({arg_hi_q, rx_data});
          state_d    = IDLE;
        end
      end

      GATING: begin
        // First GATING cycle is the clear cycle; a zero-length gate ends right there.
        end_gate = cnt_clear_q ? (gate_len_q == '0) : timer_expire_c;
        if (rx_valid && (rx_data == OP_STOP)) begin
          end_gate = 1'b1;
        end
        if (end_gate) begin
          gate_done_d = 1'b1;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_enable_d = 1'b1;
        end
      end

      READOUT: begin
        if (rx_valid) begin
          if (bytes_left_q == '0) begin
            readout_end = 1'b1;
            state_d     = IDLE;
          end else begin
            shadow_d     = shadow_q << 8;
            present      = 1'b1;
            present_byte = shadow_d[COUNT_W-1 -: 8];
            bytes_left_d = bytes_left_q - BYTES_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (cnt_enable_q && cnt_tc) begin
      ovf_d = 1'b1;
    end

    busy_d   = (state_d == GATING) || (state_d == READOUT);
    status_d = make_status(busy_d, done_d, ovf_d, err_d);

    // Outside READOUT the host always sees the live status byte.
    if (present) begin
      tx_data_d   = present_byte;
      tx_update_d = 1'b1;
    end else if (state_d != READOUT) begin
      tx_data_d   = status_d;
      tx_update_d = readout_end || (status_d != tx_data_q);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gate_len_q   <= GATE_W'(DEFAULT_GATE);
      arg_hi_q     <= 8'h00;
      shadow_q     <= '0;
      bytes_left_q <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_update_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
      cnt_clear_q  <= 1'b0;
      busy_q       <= 1'b0;
      gate_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_len_q   <= gate_len_d;
      arg_hi_q     <= arg_hi_d;
      shadow_q     <= shadow_d;
      bytes_left_q <= bytes_left_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      tx_data_q    <= tx_data_d;
      tx_update_q  <= tx_update_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_clear_q  <= cnt_clear_d;
      busy_q       <= busy_d;
      gate_done_q  <= gate_done_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_update  = tx_update_q;
  assign cnt_enable = cnt_enable_q;
  assign cnt_clear  = cnt_clear_q;
  assign busy       = busy_q;
  assign gate_done  = gate_done_q;

endmodule

// File: tb/tb_count_gate_controller.sv
// Scenario bench for count_gate_controller: tx bytes are scoreboarded, gate
// timing is checked through pulse/cycle counters sampled on the falling edge.
module tb_count_gate_controller;
  import count_ctrl_pkg::*;

  logic        clock;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic        tx_update;
  logic        cnt_enable;
  logic        cnt_clear;
  logic [15:0] cnt_value;
  logic        cnt_tc;
  logic        busy;
  logic        gate_done;

  int passed = 0;
  int total  = 0;
  int en_cnt = 0;
  int gd_cnt = 0;
  int clr_cnt = 0;
  int obs_rd = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  count_gate_controller #(
    .COUNT_W(16),
    .GATE_W(16),
    .DEFAULT_GATE(1000)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_data    (tx_data),
    .tx_update  (tx_update),
    .cnt_enable (cnt_enable),
    .cnt_clear  (cnt_clear),
    .cnt_value  (cnt_value),
    .cnt_tc     (cnt_tc),
    .busy       (busy),
    .gate_done  (gate_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tx_update === 1'b1) obs_q.push_back(tx_data);
    if (cnt_enable === 1'b1) en_cnt <= en_cnt + 1;
    if (gate_done === 1'b1) gd_cnt <= gd_cnt + 1;
    if (cnt_clear === 1'b1) clr_cnt <= clr_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Byte is sampled at the next rising edge; returns 1 time unit after it.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({tx_data, tx_update, cnt_enable, cnt_clear, busy, gate_done} !== 13'h0)
      $display("FAIL reset_outputs got=%h exp=0",
               {tx_data, tx_update, cnt_enable, cnt_clear, busy, gate_done});
    else passed++;
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_stop();
    logic [7:0] e, o;
    int en0, gd0;
    en0 = en_cnt; gd0 = gd_cnt;
    send_byte(OP_START); exp_q.push_back(8'h80);
    wait_cyc(10);
    send_byte(OP_STOP); exp_q.push_back(8'h40);
    total++;
    if ({cnt_enable, gate_done, busy} !== 3'b010)
      $display("FAIL stop_edge {en,done,busy} got=%b exp=010", {cnt_enable, gate_done, busy});
    else passed++;
    total++;
    if (en_cnt - en0 != 10) $display("FAIL stop_en_cycles got=%0d exp=10", en_cnt - en0);
    else passed++;
    wait_cyc(1100);
    total++;
    if (gd_cnt - gd0 != 1) $display("FAIL stop_gate_done got=%0d exp=1", gd_cnt - gd0);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx; obs_rd++;
      total++;
      if (o !== e) $display("FAIL stop_sb tx_data got=%h exp=%h", o, e); else passed++;
    end
    total++;
    if (obs_q.size() != obs_rd) $display("FAIL stop_sb updates got=%0d exp=%0d", obs_q.size(), obs_rd);
    else passed++;
  endtask

  task automatic test_gate5();
    logic [7:0] e, o;
    int en0, gd0, clr0;
    send_byte(OP_SET_GATE); send_byte(8'h00); send_byte(8'h05);
    en0 = en_cnt; gd0 = gd_cnt; clr0 = clr_cnt;
    send_byte(OP_START); exp_q.push_back(8'h80);
    total++;
    if ({cnt_clear, cnt_enable, busy} !== 3'b101)
      $display("FAIL gate5_clear {clr,en,busy} got=%b exp=101", {cnt_clear, cnt_enable, busy});
    else passed++;
    wait_cyc(1);
    total++;
    if ({cnt_clear, cnt_enable} !== 2'b01)
      $display("FAIL gate5_first_en {clr,en} got=%b exp=01", {cnt_clear, cnt_enable});
    else passed++;
    exp_q.push_back(8'h40);
    wait_cyc(10);
    total++;
    if (en_cnt - en0 != 5) $display("FAIL gate5_en_cycles got=%0d exp=5", en_cnt - en0); else passed++;
    total++;
    if (gd_cnt - gd0 != 1 || clr_cnt - clr0 != 1)
      $display("FAIL gate5_pulses gd=%0d clr=%0d exp=1,1", gd_cnt - gd0, clr_cnt - clr0);
    else passed++;
    total++;
    if ({busy, tx_data} !== 9'h040) $display("FAIL gate5_status got=%h exp=040", {busy, tx_data});
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx; obs_rd++;
      total++;
      if (o !== e) $display("FAIL gate5_sb tx_data got=%h exp=%h", o, e); else passed++;
    end
    total++;
    if (obs_q.size() != obs_rd) $display("FAIL gate5_sb updates got=%0d exp=%0d", obs_q.size(), obs_rd);
    else passed++;
  endtask

  task automatic test_readout();
    logic [7:0] e, o;
    int clr0;
    clr0 = clr_cnt;
    cnt_value = 16'hBEEF;
    send_byte(OP_READ); exp_q.push_back(8'hBE);
    total++;
    if ({tx_update, busy, tx_data} !== 10'h3BE)
      $display("FAIL read_msb {upd,busy,tx} got=%h exp=3be", {tx_update, busy, tx_data});
    else passed++;
    cnt_value = 16'h1234;
    wait_cyc(2);
    send_byte(OP_START); exp_q.push_back(8'hEF);
    total++;
    if ({tx_update, tx_data} !== 9'h1EF) $display("FAIL read_lsb got=%h exp=1ef", {tx_update, tx_data});
    else passed++;
    send_byte(OP_START); exp_q.push_back(8'h40);
    total++;
    if ({tx_update, busy, tx_data} !== 10'h240)
      $display("FAIL read_end {upd,busy,tx} got=%h exp=240", {tx_update, busy, tx_data});
    else passed++;
    wait_cyc(2);
    total++;
    if (clr_cnt != clr0) $display("FAIL read_dummy_clear got=%0d exp=0", clr_cnt - clr0); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx; obs_rd++;
      total++;
      if (o !== e) $display("FAIL read_sb tx_data got=%h exp=%h", o, e); else passed++;
    end
    total++;
    if (obs_q.size() != obs_rd) $display("FAIL read_sb updates got=%0d exp=%0d", obs_q.size(), obs_rd);
    else passed++;
  endtask

  task automatic test_err();
    logic [7:0] e, o;
    int clr0, gd0;
    clr0 = clr_cnt; gd0 = gd_cnt;
    send_byte(OP_CLEAR); exp_q.push_back(8'h00);
    send_byte(8'h7F); exp_q.push_back(8'h10);
    total++;
    if (tx_data !== 8'h10) $display("FAIL err_status got=%h exp=10", tx_data); else passed++;
    send_byte(OP_STOP);
    wait_cyc(2);
    total++;
    if ({tx_data, gate_done} !== 9'h020 || gd_cnt != gd0)
      $display("FAIL err_idle_stop got=%h gd=%0d exp=020,0", {tx_data, gate_done}, gd_cnt - gd0);
    else passed++;
    send_byte(OP_CLEAR); exp_q.push_back(8'h00);
    wait_cyc(2);
    total++;
    if ({tx_data, clr_cnt - clr0} !== {8'h00, 32'd2})
      $display("FAIL err_clear tx=%h clr=%0d exp=00,2", tx_data, clr_cnt - clr0);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx; obs_rd++;
      total++;
      if (o !== e) $display("FAIL err_sb tx_data got=%h exp=%h", o, e); else passed++;
    end
    total++;
    if (obs_q.size() != obs_rd) $display("FAIL err_sb updates got=%0d exp=%0d", obs_q.size(), obs_rd);
    else passed++;
  endtask

  task automatic test_ovf();
    logic [7:0] e, o;
    send_byte(OP_START); exp_q.push_back(8'h80);
    wait_cyc(2);
    cnt_tc = 1'b1;
    wait_cyc(1);
    cnt_tc = 1'b0;
    exp_q.push_back(8'hA0);
    total++;
    if ({tx_update, tx_data} !== 9'h1A0) $display("FAIL ovf_set got=%h exp=1a0", {tx_update, tx_data});
    else passed++;
    exp_q.push_back(8'h60);
    wait_cyc(6);
    total++;
    if (tx_data !== 8'h60) $display("FAIL ovf_done_status got=%h exp=60", tx_data); else passed++;
    cnt_tc = 1'b1;
    wait_cyc(2);
    cnt_tc = 1'b0;
    total++;
    if (tx_data !== 8'h60) $display("FAIL ovf_idle_tc got=%h exp=60", tx_data); else passed++;
    send_byte(OP_START); exp_q.push_back(8'h80);
    total++;
    if (tx_data !== 8'h80) $display("FAIL ovf_restart got=%h exp=80", tx_data); else passed++;
    exp_q.push_back(8'h40);
    wait_cyc(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx; obs_rd++;
      total++;
      if (o !== e) $display("FAIL ovf_sb tx_data got=%h exp=%h", o, e); else passed++;
    end
    total++;
    if (obs_q.size() != obs_rd) $display("FAIL ovf_sb updates got=%0d exp=%0d", obs_q.size(), obs_rd);
    else passed++;
  endtask

  task automatic test_gate0();
    logic [7:0] e, o;
    int en0, gd0;
    send_byte(OP_SET_GATE); send_byte(8'h00); send_byte(8'h00);
    en0 = en_cnt; gd0 = gd_cnt;
    send_byte(OP_START); exp_q.push_back(8'h80);
    wait_cyc(1);
    exp_q.push_back(8'h40);
    total++;
    if ({gate_done, cnt_enable, cnt_clear} !== 3'b100)
      $display("FAIL gate0_done {gd,en,clr} got=%b exp=100", {gate_done, cnt_enable, cnt_clear});
    else passed++;
    wait_cyc(3);
    total++;
    if (en_cnt != en0 || gd_cnt - gd0 != 1)
      $display("FAIL gate0_counts en=%0d gd=%0d exp=0,1", en_cnt - en0, gd_cnt - gd0);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx; obs_rd++;
      total++;
      if (o !== e) $display("FAIL gate0_sb tx_data got=%h exp=%h", o, e); else passed++;
    end
    total++;
    if (obs_q.size() != obs_rd) $display("FAIL gate0_sb updates got=%0d exp=%0d", obs_q.size(), obs_rd);
    else passed++;
  endtask

  task automatic test_stop_last();
    int en0, gd0;
    send_byte(OP_SET_GATE); send_byte(8'h00); send_byte(8'h03);
    en0 = en_cnt; gd0 = gd_cnt;
    send_byte(OP_START); exp_q.push_back(8'h80);
    wait_cyc(3);
    send_byte(OP_STOP); exp_q.push_back(8'h40);
    total++;
    if (gate_done !== 1'b1) $display("FAIL stoplast_edge gate_done got=%b exp=1", gate_done); else passed++;
    wait_cyc(4);
    total++;
    if (en_cnt - en0 != 3 || gd_cnt - gd0 != 1)
      $display("FAIL stoplast_counts en=%0d gd=%0d exp=3,1", en_cnt - en0, gd_cnt - gd0);
    else passed++;
  endtask

  task automatic test_rst();
    logic [7:0] e, o;
    int en0, n;
    send_byte(OP_START); exp_q.push_back(8'h80);
    wait_cyc(1);
    total++;
    if (cnt_enable !== 1'b1) $display("FAIL rst_pre_enable got=%b exp=1", cnt_enable); else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({tx_data, tx_update, cnt_enable, cnt_clear, busy, gate_done} !== 13'h0)
      $display("FAIL rst_gating_async got=%h exp=0",
               {tx_data, tx_update, cnt_enable, cnt_clear, busy, gate_done});
    else passed++;
    @(posedge clock); #1 rst = 1'b0;
    wait_cyc(1);
    send_byte(OP_SET_GATE); send_byte(8'h12);
    #2 rst = 1'b1;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    wait_cyc(1);
    send_byte(8'h34); exp_q.push_back(8'h10);
    total++;
    if ({tx_update, tx_data} !== 9'h110) $display("FAIL rst_setgate_drop got=%h exp=110", {tx_update, tx_data});
    else passed++;
    send_byte(OP_CLEAR); exp_q.push_back(8'h00);
    en0 = en_cnt;
    send_byte(OP_START); exp_q.push_back(8'h80);
    n = 0;
    while (gate_done !== 1'b1 && n < 1200) begin
      wait_cyc(1);
      n++;
    end
    exp_q.push_back(8'h40);
    total++;
    if (gate_done !== 1'b1) $display("FAIL rst_default_gate timeout gate_done=%b exp=1", gate_done);
    else passed++;
    total++;
    if (en_cnt - en0 != 1000) $display("FAIL rst_default_gate en_cycles got=%0d exp=1000", en_cnt - en0);
    else passed++;
    wait_cyc(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx; obs_rd++;
      total++;
      if (o !== e) $display("FAIL rst_sb tx_data got=%h exp=%h", o, e); else passed++;
    end
    total++;
    if (obs_q.size() != obs_rd) $display("FAIL rst_sb updates got=%0d exp=%0d", obs_q.size(), obs_rd);
    else passed++;
  endtask

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cnt_value = 16'h0000;
    cnt_tc    = 1'b0;
    test_reset();
    test_stop();
    test_gate5();
    test_readout();
    test_err();
    test_ovf();
    test_gate0();
    test_stop_last();
    test_rst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
